// File: rtl/mac_sequencer.sv
// Sequencer for a shift-add multiply-accumulate: it drives the external result register
// through load/add/shift over N_BITS iterations, then folds the product into the accumulator.
module mac_sequencer #(
    parameter int N_BITS = 8,
    parameter int ACC_W  = 20   // must be >= 2*N_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  acc_en,
    input  logic                  clear_acc,
    input  logic [N_BITS-1:0]     a_in,
    input  logic [N_BITS-1:0]     b_in,
    output logic                  ready,
    output logic                  done,
    output logic [N_BITS-1:0]     a_out,
    output logic [N_BITS-1:0]     b_load,
    output logic                  load_mul,
    output logic                  do_add,
    output logic                  do_shift,
    input  logic                  lsb,
    input  logic [2*N_BITS-1:0]   mult_out,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  overflow
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [N_BITS-1:0]   r_a;
    logic [N_BITS-1:0]   r_b;
    logic                r_acc_en;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;

    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W:0]      w_sum;

    assign w_prod_ext = {{(ACC_W-2*N_BITS){1'b0}}, mult_out};
    // One extra bit captures the carry out of the accumulator's top bit.
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc_en <= 1'b0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A simultaneous start still sees the cleared accumulator at ACCUM.
                    if (clear_acc) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_acc_en <= acc_en;
                        r_cnt    <= '0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD:  r_state <= S_ADD;
                S_ADD:   r_state <= S_SHIFT;
                S_SHIFT: begin
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_ACCUM;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ACCUM: begin
                    if (r_acc_en) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                    end else begin
                        r_acc <= w_prod_ext;
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The add flag is armed one cycle ahead of the shift that consumes it.
    assign ready    = (r_state == S_IDLE);
    assign done     = (r_state == S_DONE);
    assign load_mul = (r_state == S_LOAD);
    assign do_add   = (r_state == S_ADD) & lsb;
    assign do_shift = (r_state == S_SHIFT);
    assign a_out    = r_a;
    assign b_load   = r_b;
    assign acc_out  = r_acc;
    assign overflow = r_ovf;

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller for the 8-bit shift-add multiplier result register. It accepts a multiply-accumulate request and latches operands.
- It sequences load/add/shift over N iterations, then accumulates the 2N-bit product into an ACC_W-bit accumulator.
- It sits between the upstream requester and the multiplier datapath, which consists of the result register plus an external N-bit adder computing b_out + a_out.

Parameters:
N_BITS, 8, operand width; iteration count
ACC_W, 20, accumulator width (must be >= 2*N_BITS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when ready=1
acc_en  in  1  sampled with start: 1 = add product to acc, 0 = overwrite acc with product
clear_acc  in  1  clears acc_out and overflow; honoured only in IDLE
a_in  in  N_BITS  multiplicand, sampled on accept
b_in  in  N_BITS  multiplier, sampled on accept
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse; acc_out valid
a_out  out  N_BITS  latched multiplicand to external adder
b_load  out  N_BITS  latched multiplier to result register b_in
load_mul  out  1  result-register load strobe
do_add  out  1  result-register add-arm strobe
do_shift  out  1  result-register shift strobe
lsb  in  1  result-register LSB
mult_out  in  2*N_BITS  result-register product
acc_out  out  ACC_W  accumulator
overflow  out  1  sticky accumulator carry-out

Behaviour:
Interface:
- One clock, clk. reset is asynchronous and active-high.
- Reset forces state IDLE and counter=0.
- Reset values: a_out=0, b_load=0, acc_out=0, overflow=0, load_mul=0, do_add=0, do_shift=0, done=0, ready=1.
- Reset mid-operation abandons the operation immediately. No done is issued.

State machine:
- States: IDLE, LOAD, ADD, SHIFT, ACCUM, DONE. Strobes are decoded combinationally from state.
- IDLE: ready=1.
  - If clear_acc=1: acc_out<=0 and overflow<=0.
  - If start=1: latch a_in, b_in and acc_en; counter<=0; go to LOAD.
  - start and clear_acc together: the clear takes effect first, and the operation then accumulates onto zero.
- LOAD: load_mul=1; go to ADD.
- ADD: do_add=lsb; go to SHIFT.
  - The add strobe must precede the shift by one cycle, because the result register uses the previously armed add flag on the shift.
- SHIFT: do_shift=1.
  - If counter==N_BITS-1: go to ACCUM.
  - Otherwise: counter<=counter+1; go to ADD.
- ACCUM: no strobes. On the clock edge leaving ACCUM:
  - If acc_en: acc_out <= acc_out + zero-extended mult_out, modulo 2^ACC_W; overflow |= carry out of bit ACC_W-1.
  - Else: acc_out <= zero-extended mult_out; overflow unchanged.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.

Timing and rules:
- Latency: start accepted at edge E0. load_mul is high for E0..E1. ADD/SHIFT pairs occupy 2*N_BITS cycles. acc_out updates at E(2N+2). done is high in the cycle after E(2N+2), i.e. E18 to E19 for N=8. Fixed latency, independent of operand values.
- start outside IDLE is ignored, with no queuing.
- clear_acc outside IDLE is ignored.
- a_out and b_load hold until the next accept. Upstream may change a_in/b_in freely after accept.
- do_add and do_shift are never high in the same cycle. load_mul is never high together with either.
- Counter width: clog2(N_BITS). The counter does not wrap within an operation.

Test Plan:
- Reset, then start a=5, b=3, acc_en=0 -> do_add high in iterations 0 and 1 only; done exactly 18 cycles after accept; acc_out=15, overflow=0.
- Follow with a=255, b=255, acc_en=1 -> acc_out=65040; mult_out=65025 at ACCUM.
- clear_acc, then 17 back-to-back ops 255x255 with acc_en=1 -> after the 16th op acc_out=1040400, overflow=0; after the 17th op acc_out=56849, overflow=1. clear_acc then clears both.
- a=200, b=0 -> do_add never asserted; acc_out=0 (acc_en=0). Pulse start again during SHIFT -> ignored; only one done.
- Assert reset during iteration 4 of an op -> all outputs at reset values next cycle; no done. A new op 7x9 after release yields acc_out=63.
- start and clear_acc together with acc_out=100, a=2, b=2, acc_en=1 -> acc_out=4.
